// File: rtl/seq_square_q16_if.sv
// Operand/result handshake bundle for the Q16.16 squarer.
// The master side issues operands and accepts results; the slave side is the squarer.
interface seq_square_q16_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/seq_square_q16.sv
// Multi-cycle unsigned fixed-point squarer: result = floor(x*x >> FRAC), saturating,
// computed by shift-and-add one multiplier bit per clock with valid/ready on both sides.
module seq_square_q16 #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_square_q16_if.slave  sq
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    logic [2*WIDTH-1:0] acc_sum;
    logic               sat;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // Anything at or above bit WIDTH+FRAC of the full product cannot fit in the result.
    assign sat = |acc_sum[2*WIDTH-1:WIDTH+FRAC];

    assign sq.in_ready = rst_n && (state == IDLE);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is synchronous; all datapath registers are cleared so nothing stale survives an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            count        <= '0;
            sq.out_valid <= 1'b0;
            sq.result    <= '0;
            sq.overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sq.in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, sq.x};
                        mplier <= sq.x;
                        acc    <= '0;
                        count  <= '0;
                        state  <= CALC;
                    end
                end

                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        sq.out_valid <= 1'b1;
                        sq.overflow  <= sat;
                        sq.result    <= sat ? {WIDTH{1'b1}} : acc_sum[WIDTH+FRAC-1:FRAC];
                        state        <= DONE;
                    end
                end

                DONE: begin
                    if (sq.out_ready) begin
                        sq.out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    sq.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
